// File: rtl/bin2bcd_conv_pkg.sv
// Shared display codes and converter FSM encoding for the FND display path.
package bin2bcd_conv_pkg;

   // Codes the 7-segment decoder maps to a blank digit and a decimal point.
   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam logic [3:0] BCD_DOT   = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a digit of 5..9 gets +3 so the next left shift carries correctly.
module bcd_add3 (
   input  logic [3:0] i_dig,
   output logic [3:0] o_dig
);

   assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, with
// overflow and optional leading-zero blanking for the display digits.
module bin2bcd_conv
   import bin2bcd_conv_pkg::*;
#(
   parameter int BIN_W    = 14,
   parameter int DIGITS   = 4,
   parameter bit LZ_BLANK = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int          BCD_W   = 4 * DIGITS;
   localparam int          CNT_W   = $clog2(BIN_W + 1);
   localparam int unsigned MAX_VAL = 10**DIGITS - 1;

   state_t               r_state;
   state_t               w_next;
   logic [BIN_W-1:0]     r_bin;
   logic [BCD_W-1:0]     r_scratch;
   logic [CNT_W-1:0]     r_count;
   logic                 r_ovf;
   logic                 r_done;
   logic [BCD_W-1:0]     r_bcd;
   logic                 r_overflow;
   logic [BCD_W-1:0]     w_adj;
   logic [BCD_W-1:0]     w_blanked;
   logic                 w_lead;
   logic                 w_ovf_in;

   assign w_ovf_in = ({{(32-BIN_W){1'b0}}, bin} > MAX_VAL);

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_add3 u_add3 (
         .i_dig (r_scratch[4*g +: 4]),
         .o_dig (w_adj[4*g +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_SHIFT;
         ST_SHIFT:  if (r_count == CNT_W'(BIN_W - 1)) w_next = ST_FINISH;
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Blank zeros above the first nonzero digit; the units digit always shows.
   always_comb begin
      w_blanked = r_scratch;
      w_lead    = 1'b1;
      if (LZ_BLANK) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_lead && (r_scratch[4*i +: 4] == 4'h0)) w_blanked[4*i +: 4] = BCD_BLANK;
            else                                          w_lead = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin      <= '0;
         r_scratch  <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bin     <= bin;
                  r_scratch <= '0;
                  r_count   <= '0;
                  r_ovf     <= w_ovf_in;
               end
            end
            ST_SHIFT: begin
               // Bits leaving the top digit are dropped; overflow comes from the compare.
               r_scratch <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
               r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
               r_count   <= r_count + 1'b1;
            end
            ST_FINISH: begin
               r_bcd      <= r_ovf ? {DIGITS{BCD_BLANK}} : w_blanked;
               r_overflow <= r_ovf;
               r_done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign bcd      = r_bcd;
   assign overflow = r_overflow;

endmodule
